vga_window_scanner: RTL and testbench
=====================================

VGA_WINDOW_SCANNER -- requirements
Module: vga_window_scanner

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT 16, H_SYNC 96, H_BACK 48, horizontal porch and sync lengths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameters V_FRONT 10, V_SYNC 2, V_BACK 33, vertical porch and sync lengths in lines.
REQ-005 Parameter ADDR_WIDTH, default 17, width of the frame-buffer read address.
REQ-006 Parameter READ_LATENCY, default 1 (range 1..4), frame-buffer read latency in cycles.
REQ-007 CLK  in  1  pixel clock; the only clock.
REQ-008 RESET_N  in  1  reset, synchronous, active-low.
REQ-009 IMG_WIDTH_OUT  in  10  requested image width in pixels.
REQ-010 IMG_HEIGHT_OUT  in  9  requested image height in lines.
REQ-011 R_ADDR  out  ADDR_WIDTH  frame-buffer read address.
REQ-012 R_EN  out  1  read strobe, high only while R_ADDR is meaningful.
REQ-013 X_CUR_COORD, Y_CUR_COORD  out  10 each  pixel coordinate, aligned with the returned read data.
REQ-014 CUR_COORD_STATE  out  1  high when the aligned pixel lies inside the image window.
REQ-015 DISPLAY_ACTIVE  out  1  high when the aligned pixel lies inside H_DISPLAY x V_DISPLAY.
REQ-016 H_SYNC, V_SYNC  out  1 each  active-low syncs, aligned with the coordinates.
REQ-017 FRAME_START  out  1  one-cycle pulse aligned with coordinate (0,0).

Function
REQ-018 Stage 0 SHALL hold counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1), where H_TOTAL and V_TOTAL are the sums of the respective display, front, sync and back lengths; hc increments every cycle, wraps to 0 and increments vc on wrap, and vc wraps to 0 after V_TOTAL-1.
REQ-019 At hc=0,vc=0, stage 0 SHALL latch the effective width W (IMG_WIDTH_OUT, forced to H_DISPLAY if 0 or >H_DISPLAY) and height H (same rule against V_DISPLAY), plus offsets HO=(H_DISPLAY-W)>>1 and VO=(V_DISPLAY-H)>>1 (floor); input changes at any other time SHALL be ignored until the next frame.
REQ-020 Window condition: HO<=hc<HO+W and VO<=vc<VO+H, using the latched values only.
REQ-021 The address SHALL be generated incrementally with no multiplier: an internal counter clears at frame start, drives R_ADDR, and advances by 1 after each in-window pixel, wrapping modulo 2^ADDR_WIDTH.
REQ-022 R_ADDR and R_EN SHALL be registered, valid one cycle after the stage-0 counter value; R_EN=1 exactly for in-window pixels, and R_ADDR SHALL hold its last value while R_EN=0.
REQ-023 X/Y, CUR_COORD_STATE, DISPLAY_ACTIVE, H_SYNC, V_SYNC and FRAME_START SHALL be delayed 1+READ_LATENCY cycles from stage 0, so they align with read data returned READ_LATENCY cycles after R_EN.
REQ-024 H_SYNC SHALL be 0 for H_DISPLAY+H_FRONT <= hc < H_DISPLAY+H_FRONT+H_SYNC, else 1; V_SYNC follows the same rule using the vertical lengths and vc.
REQ-025 X_CUR_COORD and Y_CUR_COORD SHALL output the raw hc and vc, including blanking values.
REQ-026 Offset and bound arithmetic SHALL use at least 11 bits so that no subtraction underflows.

Reset
REQ-027 While RESET_N=0 at a CLK edge: hc, vc, the address counter and R_ADDR SHALL go to 0; R_EN, CUR_COORD_STATE, DISPLAY_ACTIVE and FRAME_START to 0; H_SYNC and V_SYNC to 1; X/Y to 0; all delay-line stages flushed to these values; latched W/H set to H_DISPLAY/V_DISPLAY.
REQ-028 A reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL be stage-0 (0,0), with frame-start latching applied.

Verification
REQ-029 Reset, then 320x240 with defaults -> HO=160, VO=120; first R_EN with R_ADDR=0 at stage (160,120); last R_EN with R_ADDR=76799 at (479,359); CUR_COORD_STATE high for 76800 cycles per frame.
REQ-030 Change width from 320 to 200 at stage (0,10) -> current frame keeps 320-wide window; next frame HO=220 with 200 pixels per line.
REQ-031 Width 700, height 0 -> W=640 and H=480 clamped; R_EN on every visible pixel; R_ADDR wraps at 131072 back to 0.
REQ-032 Sync check -> H_SYNC low exactly for aligned X in 656..751, V_SYNC low for aligned Y in 490..491; FRAME_START pulses once per 420000 cycles.
REQ-033 READ_LATENCY=3 -> CUR_COORD_STATE rises 3 cycles after the first R_EN; reset pulse at stage (300,200) -> all outputs at reset values, restart at (0,0).

Source files
------------

// File: rtl/vga_window_scanner.sv
// VGA timing generator that scans a centred image window, issuing frame-buffer
// reads and emitting coordinates/syncs delayed to line up with the returned data.
module vga_window_scanner #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    // Sync lengths carry a _LEN suffix because H_SYNC/V_SYNC name the outputs.
    parameter int H_SYNC_LEN   = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC_LEN   = 2,
    parameter int V_BACK       = 33,
    parameter int ADDR_WIDTH   = 17,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [9:0]            IMG_WIDTH_OUT,
    input  logic [8:0]            IMG_HEIGHT_OUT,
    output logic [ADDR_WIDTH-1:0] R_ADDR,
    output logic                  R_EN,
    output logic [9:0]            X_CUR_COORD,
    output logic [9:0]            Y_CUR_COORD,
    output logic                  CUR_COORD_STATE,
    output logic                  DISPLAY_ACTIVE,
    output logic                  H_SYNC,
    output logic                  V_SYNC,
    output logic                  FRAME_START
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC_LEN + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC_LEN + V_BACK;
    localparam int TW      = ($clog2(H_TOTAL) > $clog2(V_TOTAL)) ? $clog2(H_TOTAL) : $clog2(V_TOTAL);
    localparam int CW      = (TW > 11) ? TW : 11;
    localparam int unsigned DEPTH = 1 + READ_LATENCY;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] HD       = CW'(H_DISPLAY);
    localparam logic [CW-1:0] VD       = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HT_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VT_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC_LEN);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC_LEN);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       win;
        logic       disp;
        logic       hs;
        logic       vs;
        logic       fs;
    } tap_t;

    localparam tap_t TAP_RST = '{x: '0, y: '0, win: 1'b0, disp: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [CW-1:0]         hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0]         w_q, h_q, ho_q, vo_q;
    logic [CW-1:0]         w_req, h_req, w_cur, h_cur, ho_cur, vo_cur;
    logic                  frame_start0, in_window;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_base;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic                  r_en_q, r_en_d;
    tap_t                  tap0;
    tap_t [DEPTH-1:0]      pipe_q;

    always_comb begin
        hc_d = hc_q + ONE;
        vc_d = vc_q;
        if (hc_q == HT_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == VT_LAST) ? '0 : vc_q + ONE;
        end

        frame_start0 = (hc_q == '0) && (vc_q == '0);

        w_req = CW'(IMG_WIDTH_OUT);
        if (w_req == '0 || w_req > HD) w_req = HD;
        h_req = CW'(IMG_HEIGHT_OUT);
        if (h_req == '0 || h_req > VD) h_req = VD;

        // The (0,0) pixel already uses the geometry being latched for its frame.
        w_cur  = w_q;
        h_cur  = h_q;
        ho_cur = ho_q;
        vo_cur = vo_q;
        if (frame_start0) begin
            w_cur  = w_req;
            h_cur  = h_req;
            ho_cur = (HD - w_req) >> 1;
            vo_cur = (VD - h_req) >> 1;
        end

        in_window = (hc_q >= ho_cur) && (hc_q < ho_cur + w_cur) &&
                    (vc_q >= vo_cur) && (vc_q < vo_cur + h_cur);

        addr_base = frame_start0 ? '0 : addr_q;
        addr_d    = in_window ? addr_base + ADDR_WIDTH'(1) : addr_base;
        r_en_d    = in_window;
        r_addr_d  = in_window ? addr_base : r_addr_q;

        tap0.x    = hc_q[9:0];
        tap0.y    = vc_q[9:0];
        tap0.win  = in_window;
        tap0.disp = (hc_q < HD) && (vc_q < VD);
        tap0.hs   = !((hc_q >= HS_START) && (hc_q < HS_END));
        tap0.vs   = !((vc_q >= VS_START) && (vc_q < VS_END));
        tap0.fs   = frame_start0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            hc_q     <= '0;
            vc_q     <= '0;
            w_q      <= HD;
            h_q      <= VD;
            ho_q     <= '0;
            vo_q     <= '0;
            addr_q   <= '0;
            r_addr_q <= '0;
            r_en_q   <= 1'b0;
            pipe_q   <= {DEPTH{TAP_RST}};
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            w_q      <= w_cur;
            h_q      <= h_cur;
            ho_q     <= ho_cur;
            vo_q     <= vo_cur;
            addr_q   <= addr_d;
            r_addr_q <= r_addr_d;
            r_en_q   <= r_en_d;
            pipe_q   <= {pipe_q[DEPTH-2:0], tap0};
        end
    end

    assign R_ADDR          = r_addr_q;
    assign R_EN            = r_en_q;
    assign X_CUR_COORD     = pipe_q[DEPTH-1].x;
    assign Y_CUR_COORD     = pipe_q[DEPTH-1].y;
    assign CUR_COORD_STATE = pipe_q[DEPTH-1].win;
    assign DISPLAY_ACTIVE  = pipe_q[DEPTH-1].disp;
    assign H_SYNC          = pipe_q[DEPTH-1].hs;
    assign V_SYNC          = pipe_q[DEPTH-1].vs;
    assign FRAME_START     = pipe_q[DEPTH-1].fs;

endmodule

// File: tb/tb_vga_window_scanner.sv
// Bench for vga_window_scanner: reduced timing, two read latencies, randomized
// window requests and mid-frame resets checked against a frame-position model.
module tb_vga_window_scanner;

    localparam int HD = 40, HF = 4, HSL = 6, HB = 5;
    localparam int VD = 30, VF = 2, VSL = 2, VB = 3;
    localparam int AW = 10;
    localparam int HT = HD + HF + HSL + HB;
    localparam int VT = VD + VF + VSL + VB;
    localparam int FT = HT * VT;
    localparam int NCYC = 10 * FT + 3;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [9:0] img_w = 10'd24;
    logic [8:0] img_h = 9'd16;

    logic [AW-1:0] r_addr3, r_addr1;
    logic          r_en3, r_en1;
    logic [9:0]    x3, y3, x1, y1;
    logic          st3, da3, hs3, vs3, fs3;
    logic          st1, da1, hs1, vs1, fs1;

    always #5 CLK = ~CLK;

    vga_window_scanner #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC_LEN(HSL), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC_LEN(VSL), .V_BACK(VB),
        .ADDR_WIDTH(AW), .READ_LATENCY(3)
    ) u_dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .IMG_WIDTH_OUT(img_w), .IMG_HEIGHT_OUT(img_h),
        .R_ADDR(r_addr3), .R_EN(r_en3), .X_CUR_COORD(x3), .Y_CUR_COORD(y3),
        .CUR_COORD_STATE(st3), .DISPLAY_ACTIVE(da3), .H_SYNC(hs3), .V_SYNC(vs3),
        .FRAME_START(fs3)
    );

    vga_window_scanner #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC_LEN(HSL), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC_LEN(VSL), .V_BACK(VB),
        .ADDR_WIDTH(AW), .READ_LATENCY(1)
    ) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .IMG_WIDTH_OUT(img_w), .IMG_HEIGHT_OUT(img_h),
        .R_ADDR(r_addr1), .R_EN(r_en1), .X_CUR_COORD(x1), .Y_CUR_COORD(y1),
        .CUR_COORD_STATE(st1), .DISPLAY_ACTIVE(da1), .H_SYNC(hs1), .V_SYNC(vs1),
        .FRAME_START(fs1)
    );

    typedef struct {
        bit rst;
        int x, y;
        bit win, disp, hs, vs, fs;
        int addr;
    } ent_t;

    ent_t hist[$];
    int   area_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic ent_t rst_ent();
        ent_t e;
        e.rst = 1'b1; e.x = 0; e.y = 0; e.win = 1'b0; e.disp = 1'b0;
        e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.addr = 0;
        return e;
    endfunction

    // Any reset between the pixel's stage-0 cycle and its output cycle flushes it.
    function automatic ent_t pipe_exp(int k, int lat);
        for (int j = k - lat; j <= k; j++)
            if (j < 0 || hist[j].rst) return rst_ent();
        return hist[k - lat];
    endfunction

    task automatic check_taps(input string pfx, input int k, input ent_t e,
                              input logic [9:0] x, input logic [9:0] y, input logic st,
                              input logic da, input logic hs, input logic vs, input logic fs);
        check($sformatf("%s.x k=%0d", pfx, k), 32'(x), e.x);
        check($sformatf("%s.y k=%0d", pfx, k), 32'(y), e.y);
        check($sformatf("%s.state k=%0d", pfx, k), 32'(st), 32'(e.win));
        check($sformatf("%s.disp k=%0d", pfx, k), 32'(da), 32'(e.disp));
        check($sformatf("%s.hsync k=%0d", pfx, k), 32'(hs), 32'(e.hs));
        check($sformatf("%s.vsync k=%0d", pfx, k), 32'(vs), 32'(e.vs));
        check($sformatf("%s.fstart k=%0d", pfx, k), 32'(fs), 32'(e.fs));
    endtask

    initial begin
        int w_tab[8] = '{20, 0, 45, 7, 40, 1, 39, 1023};
        int h_tab[8] = '{12, 0, 31, 30, 5, 1, 29, 511};
        int p = 0, frames = 0, chg_p = -1, rst_hold = 3;
        int cur_w = HD, cur_h = VD, cur_ho = 0, cur_vo = 0;
        int exp_raddr = 0, last_fs = -1, st_cnt = 0;
        ent_t e, pe;

        for (int k = 0; k < NCYC; k++) begin
            if (rst_hold == 0 && ((frames == 4 && p == 20 * HT + 30) || (frames == 7 && p == 777)))
                rst_hold = 2;
            RESET_N = (rst_hold == 0);
            if (rst_hold > 0) rst_hold--;

            if (RESET_N && p == chg_p) begin
                if (frames < 8) begin
                    img_w = 10'(w_tab[frames]);
                    img_h = 9'(h_tab[frames]);
                end else begin
                    img_w = 10'($urandom_range(50, 0));
                    img_h = 9'($urandom_range(40, 0));
                end
            end

            if (!RESET_N) begin
                e = rst_ent();
            end else begin
                if (p == 0) begin
                    frames++;
                    chg_p  = $urandom_range(FT - 1, 1);
                    cur_w  = (img_w == 0 || int'(img_w) > HD) ? HD : int'(img_w);
                    cur_h  = (img_h == 0 || int'(img_h) > VD) ? VD : int'(img_h);
                    cur_ho = (HD - cur_w) / 2;
                    cur_vo = (VD - cur_h) / 2;
                    area_q.push_back(cur_w * cur_h);
                end
                e.rst  = 1'b0;
                e.x    = p % HT;
                e.y    = p / HT;
                e.win  = (e.x >= cur_ho) && (e.x < cur_ho + cur_w) &&
                         (e.y >= cur_vo) && (e.y < cur_vo + cur_h);
                e.disp = (e.x < HD) && (e.y < VD);
                e.hs   = !((e.x >= HD + HF) && (e.x < HD + HF + HSL));
                e.vs   = !((e.y >= VD + VF) && (e.y < VD + VF + VSL));
                e.fs   = (p == 0);
                e.addr = ((e.y - cur_vo) * cur_w + (e.x - cur_ho)) % (1 << AW);
            end
            hist.push_back(e);

            @(posedge CLK);
            #1;

            if (e.rst) exp_raddr = 0;
            else if (e.win) exp_raddr = e.addr;
            check($sformatf("d3.r_en k=%0d", k), 32'(r_en3), 32'(e.win));
            check($sformatf("d3.r_addr k=%0d", k), 32'(r_addr3), exp_raddr);
            check($sformatf("d1.r_en k=%0d", k), 32'(r_en1), 32'(e.win));
            check($sformatf("d1.r_addr k=%0d", k), 32'(r_addr1), exp_raddr);

            pe = pipe_exp(k, 3);
            check_taps("d3", k, pe, x3, y3, st3, da3, hs3, vs3, fs3);
            pe = pipe_exp(k, 1);
            check_taps("d1", k, pe, x1, y1, st1, da1, hs1, vs1, fs1);

            if (e.rst) begin
                area_q.delete();
                last_fs = -1;
                st_cnt = 0;
            end else begin
                if (fs3 === 1'b1) begin
                    if (last_fs >= 0 && area_q.size() > 0) begin
                        check($sformatf("frame_period k=%0d", k), k - last_fs, FT);
                        check($sformatf("window_pixels k=%0d", k), st_cnt, area_q.pop_front());
                    end
                    last_fs = k;
                    st_cnt = 0;
                end
                if (st3 === 1'b1) st_cnt++;
            end

            p = e.rst ? 0 : (p + 1) % FT;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
